// File: rtl/serv_bufreg_seq.sv
// serv_bufreg_seq
// Sequences the buffer-register datapath of the bit/nibble-serial core through
// an init phase, an optional wait (memory) or delay (shift) phase and an
// execute phase. One operation is accepted at a time from IDLE.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_start                   start request, sampled only in IDLE
//   i_op                      00 ADDR, 01 MEM, 10 SLL, 11 SR
//   i_sh_signed, i_shamt      shift controls, latched at start
//   i_dbus_ack                data-bus acknowledge, sampled only in WAIT
//   o_busy, o_done            activity flag and one-cycle completion pulse
//   o_en, o_init              buffer register enable and init-phase flag
//   o_cnt0, o_cnt1            first / second cycle of an enabled phase
//   o_shift_op, o_right_shift_op, o_sh_signed   latched op decode
//   o_shift_counter_lsb       low shift-amount bits for the buffer register
//   o_dbus_cyc                data-bus request
module serv_bufreg_seq #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic          i_sh_signed,
    input  logic [4:0]    i_shamt,
    input  logic          i_dbus_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_en,
    output logic          o_init,
    output logic          o_cnt0,
    output logic          o_cnt1,
    output logic          o_shift_op,
    output logic          o_right_shift_op,
    output logic          o_sh_signed,
    output logic [LB:0]   o_shift_counter_lsb,
    output logic          o_dbus_cyc
);

    localparam int CW = 5 - LB;

    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_SR   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT,
        SHDLY,
        EXEC
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      shamt_q, shamt_d;
    logic            signed_q, signed_d;

    logic            last_cnt;
    logic [CW-1:0]   dly_len;

    // A phase is N = 2^CW cycles long, so its last cycle is the all-ones count.
    assign last_cnt = &cnt_q;
    // The upper shift-amount bits become whole idle cycles; the lower bits
    // are handled inside the buffer register via o_shift_counter_lsb.
    assign dly_len  = shamt_q[4:LB];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        op_d     = op_q;
        shamt_d  = shamt_q;
        signed_d = signed_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    state_d  = INIT;
                    op_d     = i_op;
                    shamt_d  = i_shamt;
                    signed_d = i_sh_signed;
                end
            end
            INIT: begin
                cnt_d = cnt_q + CW'(1);
                if (last_cnt) begin
                    cnt_d = '0;
                    if (op_q == OP_ADDR) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        op_d     = '0;
                        shamt_d  = '0;
                        signed_d = 1'b0;
                    end else if (op_q == OP_MEM) begin
                        state_d = WAIT;
                    end else if (dly_len != '0) begin
                        state_d = SHDLY;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            WAIT: begin
                cnt_d = '0;
                if (i_dbus_ack) begin
                    state_d = EXEC;
                end
            end
            SHDLY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == dly_len - CW'(1)) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (last_cnt) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    op_d     = '0;
                    shamt_d  = '0;
                    signed_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            op_q     <= '0;
            shamt_q  <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            op_q     <= op_d;
            shamt_q  <= shamt_d;
            signed_q <= signed_d;
        end
    end

    assign o_busy           = (state_q != IDLE);
    assign o_done           = done_q;
    assign o_en             = (state_q == INIT) || (state_q == EXEC);
    assign o_init           = (state_q == INIT);
    assign o_cnt0           = (cnt_q == '0) && o_en;
    assign o_cnt1           = (cnt_q == CW'(1)) && o_en;
    assign o_dbus_cyc       = (state_q == WAIT);
    // Latched fields are cleared on the way back to IDLE, so these decode to 0 there.
    assign o_shift_op       = op_q[1];
    assign o_right_shift_op = (op_q == OP_SR);
    assign o_sh_signed      = signed_q && (op_q == OP_SR);

    generate
        if (LB > 0) begin : g_lsb
            assign o_shift_counter_lsb = {1'b0, shamt_q[LB-1:0]};
        end else begin : g_no_lsb
            assign o_shift_counter_lsb = '0;
        end
    endgenerate

endmodule
